// File: rtl/camera_pattern_source.sv
// camera_pattern_source
//   Synthetic OV7670-style camera transmitter. Emits pclk, vsync, href and
//   RGB565 bytes (high byte first, href high only for active bytes) so the
//   camera receive / vision chain can run without a physical sensor.
//
// Ports
//   clk_in       system clock
//   rst_in       synchronous active-high reset
//   enable       run frames; sampled only at frame boundaries
//   pattern      00 solid, 01 colour bars, 10 checker, 11 box
//   color_in     RGB565 colour for solid/box patterns
//   box_x/box_y  box top-left pixel / line
//   pclk_out     camera pixel clock (clk_in / PCLK_DIV)
//   vsync_out    frame sync, active high
//   href_out     line valid, active high
//   pixel_out    data byte
//   frame_start  1-clk pulse on the edge vsync_out rises
//   frame_count  frames started, wraps 255->0
module camera_pattern_source #(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int PCLK_DIV    = 2,
  parameter int BOX_SIZE    = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable,
  input  logic [1:0]  pattern,
  input  logic [15:0] color_in,
  input  logic [9:0]  box_x,
  input  logic [8:0]  box_y,
  output logic        pclk_out,
  output logic        vsync_out,
  output logic        href_out,
  output logic [7:0]  pixel_out,
  output logic        frame_start,
  output logic [7:0]  frame_count
);

  localparam int LINE_TICKS = 2 * H_ACTIVE + H_BLANK;
  localparam int TICK_W     = $clog2(LINE_TICKS);
  localparam int P_W        = $clog2(PCLK_DIV);
  localparam int HALF       = PCLK_DIV / 2;
  localparam int MAX_AB     = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int MAX_CD     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int LINE_MAX   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int LINE_W     = $clog2(LINE_MAX + 1);
  localparam int BAR_W      = H_ACTIVE / 8;
  localparam int BAR_PX_W   = $clog2(BAR_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_VFRONT
  } state_t;

  state_t              state_q, state_d;
  logic [P_W-1:0]      p_q, p_d;
  logic                pclk_q, pclk_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [BAR_PX_W-1:0] bar_px_q, bar_px_d;
  logic [2:0]          bar_idx_q, bar_idx_d;
  logic [1:0]          pattern_q, pattern_d;
  logic [15:0]         color_q, color_d;
  logic [9:0]          box_x_q, box_x_d;
  logic [8:0]          box_y_q, box_y_d;
  logic                vsync_q, vsync_d;
  logic                href_q, href_d;
  logic [7:0]          pixel_q, pixel_d;
  logic                frame_start_q, frame_start_d;
  logic [7:0]          frame_count_q, frame_count_d;

  logic                tick_en, line_end, line_last, start_frame;
  logic [LINE_W-1:0]   last_line;
  logic [9:0]          px_x;
  logic [8:0]          px_y;
  logic [15:0]         colour;
  logic                in_box_x, in_box_y;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves one unassigned, which would otherwise infer a latch.
    p_d           = (p_q == P_W'(PCLK_DIV - 1)) ? '0 : p_q + 1'b1;
    pclk_d        = (p_q < P_W'(HALF));
    // The edge where pclk falls is the only point the video outputs move,
    // keeping them stable across every pclk rising edge.
    tick_en       = (p_q == P_W'(HALF));
    state_d       = state_q;
    tick_d        = tick_q;
    line_d        = line_q;
    bar_px_d      = bar_px_q;
    bar_idx_d     = bar_idx_q;
    pattern_d     = pattern_q;
    color_d       = color_q;
    box_x_d       = box_x_q;
    box_y_d       = box_y_q;
    vsync_d       = vsync_q;
    href_d        = href_q;
    pixel_d       = pixel_q;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;
    line_end      = (tick_q == TICK_W'(LINE_TICKS - 1));
    start_frame   = 1'b0;
    px_x          = '0;
    px_y          = '0;
    colour        = '0;
    in_box_x      = 1'b0;
    in_box_y      = 1'b0;

    case (state_q)
      ST_VSYNC:  last_line = LINE_W'(VSYNC_LINES - 1);
      ST_VBACK:  last_line = LINE_W'(V_BACK - 1);
      ST_ACTIVE: last_line = LINE_W'(V_ACTIVE - 1);
      ST_VFRONT: last_line = LINE_W'(V_FRONT - 1);
      default:   last_line = '0;
    endcase
    line_last = (line_q == last_line);

    if (tick_en) begin
      // Counters and outputs advance together, so outputs are derived from
      // the next-tick position rather than the current one.
      tick_d = line_end ? '0 : tick_q + 1'b1;
      if (line_end) begin
        line_d = line_last ? '0 : line_q + 1'b1;
        case (state_q)
          ST_IDLE:   start_frame = enable;
          ST_VSYNC:  if (line_last) state_d = ST_VBACK;
          ST_VBACK:  if (line_last) state_d = ST_ACTIVE;
          ST_ACTIVE: if (line_last) state_d = ST_VFRONT;
          ST_VFRONT: if (line_last) begin
                       if (enable) start_frame = 1'b1;
                       else        state_d     = ST_IDLE;
                     end
          default:   state_d = ST_IDLE;
        endcase
      end

      // Frame inputs are captured only here, so mid-frame changes cannot tear.
      if (start_frame) begin
        state_d       = ST_VSYNC;
        line_d        = '0;
        pattern_d     = pattern;
        color_d       = color_in;
        box_x_d       = box_x;
        box_y_d       = box_y;
        frame_count_d = frame_count_q + 1'b1;
        frame_start_d = 1'b1;
      end

      // Running bar index replaces a divide of x by the bar width.
      if (tick_d == '0) begin
        bar_px_d  = '0;
        bar_idx_d = '0;
      end else if (!tick_d[0]) begin
        if (bar_px_q == BAR_PX_W'(BAR_W - 1)) begin
          bar_px_d  = '0;
          bar_idx_d = bar_idx_q + 1'b1;
        end else begin
          bar_px_d  = bar_px_q + 1'b1;
        end
      end

      px_x = 10'(tick_d >> 1);
      px_y = 9'(line_d);
      // Sums are one bit wider than the coordinates so a box near the edge
      // clips instead of wrapping back to pixel 0.
      in_box_x = (px_x >= box_x_q) &&
                 ({1'b0, px_x} < ({1'b0, box_x_q} + 11'(BOX_SIZE)));
      in_box_y = (px_y >= box_y_q) &&
                 ({1'b0, px_y} < ({1'b0, box_y_q} + 10'(BOX_SIZE)));

      case (pattern_q)
        2'b00: colour = color_q;
        2'b01: begin
          case (bar_idx_d)
            3'd0:    colour = 16'hFFFF;
            3'd1:    colour = 16'hFFE0;
            3'd2:    colour = 16'h07FF;
            3'd3:    colour = 16'h07E0;
            3'd4:    colour = 16'hF81F;
            3'd5:    colour = 16'hF800;
            3'd6:    colour = 16'h001F;
            default: colour = 16'h0000;
          endcase
        end
        2'b10:   colour = (px_x[4] ^ px_y[4]) ? 16'hFFFF : 16'h0000;
        default: colour = (in_box_x && in_box_y) ? color_q : 16'h0000;
      endcase

      vsync_d = (state_d == ST_VSYNC);
      href_d  = (state_d == ST_ACTIVE) && (tick_d < TICK_W'(2 * H_ACTIVE));
      pixel_d = href_d ? (tick_d[0] ? colour[7:0] : colour[15:8]) : 8'h00;
    end
  end

  always_ff @(posedge clk_in) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst_in) begin
      state_q       <= ST_IDLE;
      p_q           <= '0;
      pclk_q        <= 1'b0;
      tick_q        <= '0;
      line_q        <= '0;
      bar_px_q      <= '0;
      bar_idx_q     <= '0;
      pattern_q     <= '0;
      color_q       <= '0;
      box_x_q       <= '0;
      box_y_q       <= '0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      pixel_q       <= '0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      p_q           <= p_d;
      pclk_q        <= pclk_d;
      tick_q        <= tick_d;
      line_q        <= line_d;
      bar_px_q      <= bar_px_d;
      bar_idx_q     <= bar_idx_d;
      pattern_q     <= pattern_d;
      color_q       <= color_d;
      box_x_q       <= box_x_d;
      box_y_q       <= box_y_d;
      vsync_q       <= vsync_d;
      href_q        <= href_d;
      pixel_q       <= pixel_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign pclk_out    = pclk_q;
  assign vsync_out   = vsync_q;
  assign href_out    = href_q;
  assign pixel_out   = pixel_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_camera_pattern_source.sv
// tb_camera_pattern_source
//   Small-geometry bench for camera_pattern_source: 8x4 active pixels,
//   20-tick lines, 7-line (280 clk) frames. Expected bytes for each frame are
//   queued when the frame starts; a monitor pops them on every pclk rising
//   edge with href high and also checks blanking, line length, vsync length
//   and that outputs only move on pclk falling edges.
module tb_camera_pattern_source;

  localparam int H_ACTIVE    = 8;
  localparam int V_ACTIVE    = 4;
  localparam int H_BLANK     = 4;
  localparam int VSYNC_LINES = 1;
  localparam int V_BACK      = 1;
  localparam int V_FRONT     = 1;
  localparam int PCLK_DIV    = 2;
  localparam int BOX_SIZE    = 2;
  localparam int LINE_CLKS   = 40;
  localparam int FRAME_CLKS  = 280;

  localparam logic [7:0] BAR_BYTES [16] = '{
    8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
    8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

  logic        clk = 1'b0;
  logic        rst_in;
  logic        enable;
  logic [1:0]  pattern;
  logic [15:0] color_in;
  logic [9:0]  box_x;
  logic [8:0]  box_y;
  logic        pclk_out, vsync_out, href_out, frame_start;
  logic [7:0]  pixel_out, frame_count;

  camera_pattern_source #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
    .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT),
    .PCLK_DIV(PCLK_DIV), .BOX_SIZE(BOX_SIZE)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .enable(enable), .pattern(pattern),
    .color_in(color_in), .box_x(box_x), .box_y(box_y),
    .pclk_out(pclk_out), .vsync_out(vsync_out), .href_out(href_out),
    .pixel_out(pixel_out), .frame_start(frame_start),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q [$];
  logic       mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_start(output int t);
    int n;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!frame_start && n < 3000);
    if (!frame_start) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_start_timeout: no frame_start within %0d clks", n);
      finish_run();
    end
    t = cyc;
  endtask

  task automatic push_solid(input logic [15:0] c);
    for (int i = 0; i < V_ACTIVE * H_ACTIVE; i++) begin
      exp_q.push_back(c[15:8]);
      exp_q.push_back(c[7:0]);
    end
  endtask

  task automatic push_bars();
    for (int y = 0; y < V_ACTIVE; y++)
      for (int b = 0; b < 2 * H_ACTIVE; b++) exp_q.push_back(BAR_BYTES[b]);
  endtask

  // Box at (7,3), size 2, on an 8x4 screen: only pixel (7,3) is lit.
  task automatic push_box();
    for (int y = 0; y < V_ACTIVE; y++)
      for (int x = 0; x < H_ACTIVE; x++) begin
        exp_q.push_back((x == 7 && y == 3) ? 8'hFF : 8'h00);
        exp_q.push_back((x == 7 && y == 3) ? 8'hFF : 8'h00);
      end
  endtask

  // Monitor
  logic       pclk_prev = 1'b0, href_prev = 1'b0, vsync_prev = 1'b0;
  logic [9:0] bus_prev  = '0;
  int         href_run  = 0;
  int         vsync_run = 0;

  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      if ({vsync_out, href_out, pixel_out} != bus_prev)
        check("change_on_pclk_fall", {pclk_prev, pclk_out}, 2'b10);
      if (pclk_out && !pclk_prev) begin
        if (href_out) begin
          href_run++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pixel_extra: got byte %0h, expected no byte", pixel_out);
          end else begin
            check("pixel_byte", pixel_out, exp_q.pop_front());
          end
        end else begin
          check("blank_pixel_zero", pixel_out, 8'h00);
        end
      end
      if (href_prev && !href_out) begin
        check("href_line_ticks", href_run, 2 * H_ACTIVE);
        href_run = 0;
      end
      if (vsync_out) vsync_run++;
      if (vsync_prev && !vsync_out) begin
        check("vsync_clks", vsync_run, VSYNC_LINES * LINE_CLKS);
        vsync_run = 0;
      end
    end
    pclk_prev  = pclk_out;
    href_prev  = href_out;
    vsync_prev = vsync_out;
    bus_prev   = {vsync_out, href_out, pixel_out};
  end

  initial begin
    int t_prev, t_now, t_en, starts, vs_hi, hr_hi, rises, n;
    logic pc_prev;

    rst_in   = 1'b1;
    enable   = 1'b1;
    pattern  = 2'b00;
    color_in = 16'hF81F;
    box_x    = '0;
    box_y    = '0;
    wait_clks(3);
    check("rst_pclk", pclk_out, 1'b0);
    check("rst_vsync", vsync_out, 1'b0);
    check("rst_href", href_out, 1'b0);
    check("rst_pixel", pixel_out, 8'h00);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_frame_count", frame_count, 8'h00);

    rst_in = 1'b0;
    mon_en = 1'b1;
    wait_clks(1);
    check("pclk_first_rise", pclk_out, 1'b1);

    // Frame 1: solid F81F
    wait_start(t_prev);
    check("f1_count", frame_count, 8'd1);
    check("f1_vsync_rises", vsync_out, 1'b1);
    push_solid(16'hF81F);
    pattern = 2'b01;
    wait_clks(1);
    check("frame_start_one_clk", frame_start, 1'b0);

    // Frame 2: colour bars
    wait_start(t_now);
    check("f2_period", t_now - t_prev, FRAME_CLKS);
    check("f2_count", frame_count, 8'd2);
    check("f1_all_bytes_sent", exp_q.size(), 0);
    push_bars();
    pattern  = 2'b11;
    color_in = 16'hFFFF;
    box_x    = 10'd7;
    box_y    = 9'd3;
    t_prev   = t_now;

    // Frame 3: clipped box
    wait_start(t_now);
    check("f3_period", t_now - t_prev, FRAME_CLKS);
    check("f3_count", frame_count, 8'd3);
    check("f2_all_bytes_sent", exp_q.size(), 0);
    push_box();
    pattern = 2'b10;
    t_prev  = t_now;

    // Frame 4: checker (all black at this resolution)
    wait_start(t_now);
    check("f4_period", t_now - t_prev, FRAME_CLKS);
    check("f3_all_bytes_sent", exp_q.size(), 0);
    push_solid(16'h0000);
    pattern  = 2'b00;
    color_in = 16'h1234;
    t_prev   = t_now;

    // Frame 5: solid 1234, colour changed mid-frame to ABCD
    wait_start(t_now);
    check("f4_all_bytes_sent", exp_q.size(), 0);
    push_solid(16'h1234);
    wait_clks(3 * LINE_CLKS);
    color_in = 16'hABCD;
    t_prev   = t_now;

    // Frame 6: new colour; enable dropped during the active region
    wait_start(t_now);
    check("f6_period", t_now - t_prev, FRAME_CLKS);
    check("f5_all_bytes_sent", exp_q.size(), 0);
    push_solid(16'hABCD);
    wait_clks(4 * LINE_CLKS);
    enable = 1'b0;
    t_prev = t_now;

    starts = 0;
    for (int i = 0; i < 200; i++) begin
      wait_clks(1);
      if (frame_start) starts++;
    end
    check("f6_completed", exp_q.size(), 0);
    starts = starts + 0;
    vs_hi = 0; hr_hi = 0; rises = 0;
    pc_prev = pclk_out;
    for (int i = 0; i < 200; i++) begin
      wait_clks(1);
      if (frame_start) starts++;
      if (vsync_out) vs_hi++;
      if (href_out) hr_hi++;
      if (pclk_out && !pc_prev) rises++;
      pc_prev = pclk_out;
    end
    check("idle_no_frame_start", starts, 0);
    check("idle_vsync_low", vs_hi, 0);
    check("idle_href_low", hr_hi, 0);
    check("idle_pclk_rises", rises, 100);

    // Re-enable: frame 7 starts at the next line boundary
    wait_clks(7);
    enable = 1'b1;
    t_en   = cyc;
    wait_start(t_now);
    check("reenable_latency", (t_now - t_en >= 1) && (t_now - t_en <= LINE_CLKS), 1);
    check("reenable_line_aligned", (t_now - t_prev) % LINE_CLKS, 0);
    check("f7_count", frame_count, 8'd7);
    push_solid(16'hABCD);
    t_prev = t_now;

    // Run through frame_count wrap
    for (int k = 8; k <= 257; k++) begin
      wait_start(t_now);
      check("wrap_period", t_now - t_prev, FRAME_CLKS);
      check("wrap_frame_count", frame_count, 32'(k % 256));
      check("wrap_prev_bytes_sent", exp_q.size(), 0);
      push_solid(16'hABCD);
      t_prev = t_now;
    end

    // Reset mid-line while href is high
    n = 0;
    while (!href_out && n < 400) begin wait_clks(1); n++; end
    check("href_seen_before_reset", href_out, 1'b1);
    mon_en = 1'b0;
    rst_in = 1'b1;
    wait_clks(1);
    check("midrst_pclk", pclk_out, 1'b0);
    check("midrst_vsync", vsync_out, 1'b0);
    check("midrst_href", href_out, 1'b0);
    check("midrst_pixel", pixel_out, 8'h00);
    check("midrst_frame_start", frame_start, 1'b0);
    check("midrst_frame_count", frame_count, 8'h00);
    exp_q.delete();
    finish_run();
  end

endmodule
